// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM (R-type, lw, sw, beq, j); outputs decode from state, FETCH loads gated by mem_ready.
// Memory waits hold MEM_READ/MEM_WRITE/FETCH until mem_ready; synchronous reset returns to FETCH from any state.
module mips_multicycle_control (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       write_enable,
  output logic       read_memory,
  output logic       write_memory,
  output logic       branch,
  output logic [1:0] aluop,
  output logic [1:0] alu_src_b,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       jump,
  output logic       iord,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_SHIMM = 2'b11;

  state_t r_state;
  state_t w_next;
  logic   w_pc_write_raw;
  logic   w_ir_write_raw;
  logic   w_unused;

  // zero only qualifies the branch in the datapath (PC loads when branch & zero).
  assign w_unused = zero;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:     w_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     w_next = S_R_EXEC;
          OP_LW, OP_SW: w_next = S_MEM_ADDR;
          OP_BEQ:       w_next = S_BRANCH;
          OP_J:         w_next = S_JUMP;
          default:      w_next = S_FETCH;
        endcase
      end
      S_MEM_ADDR:  w_next = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  w_next = mem_ready ? S_MEM_WB : S_MEM_READ;
      S_MEM_WB:    w_next = S_FETCH;
      S_MEM_WRITE: w_next = mem_ready ? S_FETCH : S_MEM_WRITE;
      S_R_EXEC:    w_next = S_R_WB;
      S_R_WB:      w_next = S_FETCH;
      S_BRANCH:    w_next = S_FETCH;
      S_JUMP:      w_next = S_FETCH;
      default:     w_next = S_FETCH;
    endcase
  end

  always_comb begin
    w_pc_write_raw = 1'b0;
    w_ir_write_raw = 1'b0;
    write_enable   = 1'b0;
    read_memory    = 1'b0;
    write_memory   = 1'b0;
    branch         = 1'b0;
    aluop          = ALU_ADD;
    alu_src_b      = SRCB_REG;
    reg_dst        = 1'b0;
    mem_to_reg     = 1'b0;
    jump           = 1'b0;
    iord           = 1'b0;
    instr_done     = 1'b0;
    illegal        = 1'b0;
    case (r_state)
      S_FETCH: begin
        read_memory    = 1'b1;
        alu_src_b      = SRCB_FOUR;
        w_pc_write_raw = mem_ready;
        w_ir_write_raw = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = SRCB_SHIMM;
        illegal   = !(opcode == OP_RTYPE || opcode == OP_LW || opcode == OP_SW ||
                      opcode == OP_BEQ   || opcode == OP_J);
      end
      S_MEM_ADDR: alu_src_b = SRCB_IMM;
      S_MEM_READ: begin
        read_memory = 1'b1;
        iord        = 1'b1;
      end
      S_MEM_WB: begin
        write_enable = 1'b1;
        mem_to_reg   = 1'b1;
        instr_done   = 1'b1;
      end
      S_MEM_WRITE: begin
        write_memory = 1'b1;
        iord         = 1'b1;
        instr_done   = mem_ready;
      end
      S_R_EXEC:   aluop = ALU_FUNCT;
      S_R_WB: begin
        write_enable = 1'b1;
        reg_dst      = 1'b1;
        instr_done   = 1'b1;
      end
      S_BRANCH: begin
        aluop      = ALU_SUB;
        branch     = 1'b1;
        instr_done = 1'b1;
      end
      S_JUMP: begin
        jump           = 1'b1;
        w_pc_write_raw = 1'b1;
        instr_done     = 1'b1;
      end
      default: ;
    endcase
  end

  // No architectural loads while reset is held.
  assign pc_write = w_pc_write_raw & ~rst;
  assign ir_write = w_ir_write_raw & ~rst;
  assign state    = r_state;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Scoreboard bench for mips_multicycle_control: per-cycle expected state/outputs queued at drive, compared at negedge.
module tb_mips_multicycle_control;

  localparam logic [5:0] RT  = 6'b000000;
  localparam logic [5:0] LW  = 6'b100011;
  localparam logic [5:0] SW  = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100;
  localparam logic [5:0] JMP = 6'b000010;
  localparam logic [5:0] BAD = 6'b111111;
  localparam logic [5:0] ADI = 6'b001000;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, ir_write, write_enable, read_memory, write_memory, branch;
  logic [1:0] aluop, alu_src_b;
  logic       reg_dst, mem_to_reg, jump, iord, instr_done, illegal;
  logic [3:0] state;

  always #5 clk = ~clk;

  mips_multicycle_control dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .write_enable(write_enable),
    .read_memory(read_memory), .write_memory(write_memory), .branch(branch),
    .aluop(aluop), .alu_src_b(alu_src_b), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .jump(jump), .iord(iord), .instr_done(instr_done), .illegal(illegal), .state(state)
  );

  typedef struct {
    string       tag;
    logic [3:0]  st;
    logic [15:0] outs;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] dut_outs();
    return {pc_write, ir_write, write_enable, read_memory, write_memory, branch,
            aluop, alu_src_b, reg_dst, mem_to_reg, jump, iord, instr_done, illegal};
  endfunction

  // Output table per state, written straight from the state descriptions.
  function automatic logic [15:0] model(input logic [3:0] st, input logic r, input logic mr,
                                        input logic [5:0] op);
    logic       pcw, irw, we, rm, wm, br, rd, m2r, jp, io, dn, il;
    logic [1:0] ao, sb2;
    pcw = 0; irw = 0; we = 0; rm = 0; wm = 0; br = 0; rd = 0; m2r = 0;
    jp = 0; io = 0; dn = 0; il = 0; ao = 2'b00; sb2 = 2'b00;
    case (st)
      4'd0: begin rm = 1; sb2 = 2'b01; pcw = mr & ~r; irw = mr & ~r; end
      4'd1: begin
        sb2 = 2'b11;
        il  = (op != RT) && (op != LW) && (op != SW) && (op != BEQ) && (op != JMP);
      end
      4'd2: sb2 = 2'b10;
      4'd3: begin rm = 1; io = 1; end
      4'd4: begin we = 1; m2r = 1; dn = 1; end
      4'd5: begin wm = 1; io = 1; dn = mr; end
      4'd6: ao = 2'b10;
      4'd7: begin we = 1; rd = 1; dn = 1; end
      4'd8: begin ao = 2'b01; br = 1; dn = 1; end
      4'd9: begin jp = 1; pcw = ~r; dn = 1; end
      default: ;
    endcase
    return {pcw, irw, we, rm, wm, br, ao, sb2, rd, m2r, jp, io, dn, il};
  endfunction

  task automatic step(input string tag, input logic r, input logic [5:0] op,
                      input logic mr, input logic z, input logic [3:0] st);
    exp_t e;
    rst = r; opcode = op; mem_ready = mr; zero = z;
    e.tag = tag; e.st = st; e.outs = model(st, r, mr, op);
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    chk({e.tag, "/state"}, 32'(state), 32'(e.st));
    chk({e.tag, "/outs"}, 32'(dut_outs()), 32'(e.outs));
    chk({e.tag, "/rw_excl"}, 32'(read_memory & write_memory), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; opcode = RT; zero = 1'b0; mem_ready = 1'b0;
    @(posedge clk);
    #1;
    step("rst_a", 1, RT, 0, 0, 4'd0);
    step("rst_b", 1, RT, 1, 0, 4'd0);

    // R-type, with opcode disturbed in R_EXEC
    step("r_f", 0, RT,  1, 0, 4'd0);
    step("r_d", 0, RT,  1, 0, 4'd1);
    step("r_x", 0, BAD, 1, 0, 4'd6);
    step("r_w", 0, BAD, 1, 0, 4'd7);

    // fetch wait, then lw with two MEM_READ wait cycles
    step("fw",    0, LW, 0, 0, 4'd0);
    step("lw_f",  0, LW, 1, 0, 4'd0);
    step("lw_d",  0, LW, 1, 0, 4'd1);
    step("lw_a",  0, LW, 1, 0, 4'd2);
    step("lw_r0", 0, SW, 0, 0, 4'd3);
    step("lw_r1", 0, SW, 0, 0, 4'd3);
    step("lw_r2", 0, SW, 1, 0, 4'd3);
    step("lw_wb", 0, SW, 1, 0, 4'd4);

    // sw zero wait, then sw with one wait cycle
    step("sw_f",  0, SW, 1, 0, 4'd0);
    step("sw_d",  0, SW, 1, 0, 4'd1);
    step("sw_a",  0, SW, 1, 0, 4'd2);
    step("sw_w",  0, SW, 1, 0, 4'd5);
    step("sw2_f", 0, SW, 1, 0, 4'd0);
    step("sw2_d", 0, SW, 1, 0, 4'd1);
    step("sw2_a", 0, SW, 1, 0, 4'd2);
    step("sw2_0", 0, LW, 0, 0, 4'd5);
    step("sw2_1", 0, LW, 1, 0, 4'd5);

    // beq taken and not taken follow the same path
    step("bz1_f", 0, BEQ, 1, 1, 4'd0);
    step("bz1_d", 0, BEQ, 1, 1, 4'd1);
    step("bz1_b", 0, BEQ, 1, 1, 4'd8);
    step("bz0_f", 0, BEQ, 1, 0, 4'd0);
    step("bz0_d", 0, BEQ, 1, 0, 4'd1);
    step("bz0_b", 0, BEQ, 1, 0, 4'd8);

    step("j_f", 0, JMP, 1, 0, 4'd0);
    step("j_d", 0, JMP, 1, 0, 4'd1);
    step("j_j", 0, JMP, 1, 0, 4'd9);

    // unsupported opcodes
    step("il_f",  0, BAD, 1, 0, 4'd0);
    step("il_d",  0, BAD, 1, 0, 4'd1);
    step("il2_f", 0, ADI, 1, 0, 4'd0);
    step("il2_d", 0, ADI, 1, 0, 4'd1);

    // reset mid MEM_WRITE wait
    step("rw_f", 0, SW, 1, 0, 4'd0);
    step("rw_d", 0, SW, 1, 0, 4'd1);
    step("rw_a", 0, SW, 1, 0, 4'd2);
    step("rw_w", 0, SW, 0, 0, 4'd5);
    step("rw_r", 1, SW, 0, 0, 4'd5);
    step("rw_0", 1, SW, 1, 0, 4'd0);
    step("rw_1", 1, SW, 1, 0, 4'd0);

    // reset mid MEM_READ wait
    step("rr_f", 0, LW, 1, 0, 4'd0);
    step("rr_d", 0, LW, 1, 0, 4'd1);
    step("rr_a", 0, LW, 1, 0, 4'd2);
    step("rr_m", 0, LW, 0, 0, 4'd3);
    step("rr_r", 1, LW, 0, 0, 4'd3);
    step("rr_0", 0, LW, 0, 0, 4'd0);
    step("rr_1", 0, RT, 1, 0, 4'd0);
    step("rr_2", 0, RT, 1, 0, 4'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
